// File: rtl/mux_pindai.sv
// Registered KANAL-to-1 channel selector with direct-select and auto-scan modes.
// Latency: 1 cycle from accepted input to first output beat; a scan emits KANAL beats back to back.
// Backpressure: out_ready=0 freezes the output register and scan pointer; in_ready drops while the output is stalled or a scan is running.
//
// Ports:
//   clk, rst                 clock and asynchronous active-high reset
//   masukan                  KANAL channels packed, channel c at [c*LEBAR +: LEBAR]
//   selector, mode           channel index (direct) and mode (0 direct, 1 scan), taken on input transfer
//   in_valid / in_ready      input handshake
//   keluaran, out_kanal      selected channel data and its index
//   out_valid / out_ready    output handshake
//   sel_err, scan_done       per-beat qualifiers: out-of-range selector, last beat of a scan
module mux_pindai #(
    parameter int KANAL = 4,
    parameter int LEBAR = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [KANAL*LEBAR-1:0]   masukan,
    input  logic [$clog2(KANAL)-1:0] selector,
    input  logic                     mode,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [LEBAR-1:0]         keluaran,
    output logic [$clog2(KANAL)-1:0] out_kanal,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     sel_err,
    output logic                     scan_done
);

    localparam int SW = $clog2(KANAL);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t                 state;
    logic [SW-1:0]          ptr;
    logic [KANAL*LEBAR-1:0] snapshot;

    logic                   load;
    logic                   in_xfer;
    logic [LEBAR-1:0]       dir_dat;
    logic                   dir_hit;
    logic [LEBAR-1:0]       scan_dat;

    // The output register may take a new beat when empty or being drained.
    assign load     = !out_valid || out_ready;
    assign in_ready = (state == IDLE) && load;
    assign in_xfer  = in_valid && in_ready;

    // Direct-mode lookup. A selector that matches no channel (only possible
    // for non-power-of-2 KANAL) yields zero data and clears dir_hit.
    always_comb begin
        dir_dat = '0;
        dir_hit = 1'b0;
        for (int c = 0; c < KANAL; c++) begin
            if (selector == SW'(c)) begin
                dir_dat = masukan[c*LEBAR +: LEBAR];
                dir_hit = 1'b1;
            end
        end
    end

    // Scan-mode lookup from the latched snapshot; ptr never exceeds KANAL-1.
    always_comb begin
        scan_dat = '0;
        for (int c = 0; c < KANAL; c++) begin
            if (ptr == SW'(c)) begin
                scan_dat = snapshot[c*LEBAR +: LEBAR];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            snapshot  <= '0;
            keluaran  <= '0;
            out_kanal <= '0;
            out_valid <= 1'b0;
            sel_err   <= 1'b0;
            scan_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_xfer) begin
                        out_valid <= 1'b1;
                        scan_done <= 1'b0;
                        if (!mode) begin
                            keluaran  <= dir_dat;
                            out_kanal <= selector;
                            sel_err   <= !dir_hit;
                        end else begin
                            // Channel 0 goes out straight from the input so the
                            // first scan beat has the same latency as direct mode.
                            snapshot  <= masukan;
                            keluaran  <= masukan[LEBAR-1:0];
                            out_kanal <= '0;
                            sel_err   <= 1'b0;
                            ptr       <= SW'(1);
                            state     <= SCAN;
                        end
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                SCAN: begin
                    if (load) begin
                        keluaran  <= scan_dat;
                        out_kanal <= ptr;
                        out_valid <= 1'b1;
                        sel_err   <= 1'b0;
                        if (ptr == SW'(KANAL - 1)) begin
                            scan_done <= 1'b1;
                            ptr       <= '0;
                            state     <= IDLE;
                        end else begin
                            scan_done <= 1'b0;
                            ptr       <= ptr + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_pindai.sv
// Directed bench for mux_pindai: three instances (4x1, 4x8, 3x1) exercised in turn.
// Inputs change and outputs are sampled on the falling clock edge.
// Expected values are hand-derived constants or simple bit-index arithmetic.
module tb_mux_pindai;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // KANAL=4, LEBAR=1
    logic [3:0] a_in;
    logic [1:0] a_sel, a_k;
    logic       a_mode, a_iv, a_ir, a_out, a_ov, a_or, a_err, a_done;
    // KANAL=4, LEBAR=8
    logic [31:0] b_in;
    logic [1:0]  b_sel, b_k;
    logic [7:0]  b_out;
    logic        b_mode, b_iv, b_ir, b_ov, b_or, b_err, b_done;
    // KANAL=3, LEBAR=1
    logic [2:0] c_in;
    logic [1:0] c_sel, c_k;
    logic       c_mode, c_iv, c_ir, c_out, c_ov, c_or, c_err, c_done;

    mux_pindai #(.KANAL(4), .LEBAR(1)) u_a (
        .clk(clk), .rst(rst), .masukan(a_in), .selector(a_sel), .mode(a_mode),
        .in_valid(a_iv), .in_ready(a_ir), .keluaran(a_out), .out_kanal(a_k),
        .out_valid(a_ov), .out_ready(a_or), .sel_err(a_err), .scan_done(a_done)
    );

    mux_pindai #(.KANAL(4), .LEBAR(8)) u_b (
        .clk(clk), .rst(rst), .masukan(b_in), .selector(b_sel), .mode(b_mode),
        .in_valid(b_iv), .in_ready(b_ir), .keluaran(b_out), .out_kanal(b_k),
        .out_valid(b_ov), .out_ready(b_or), .sel_err(b_err), .scan_done(b_done)
    );

    mux_pindai #(.KANAL(3), .LEBAR(1)) u_c (
        .clk(clk), .rst(rst), .masukan(c_in), .selector(c_sel), .mode(c_mode),
        .in_valid(c_iv), .in_ready(c_ir), .keluaran(c_out), .out_kanal(c_k),
        .out_valid(c_ov), .out_ready(c_or), .sel_err(c_err), .scan_done(c_done)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    logic [7:0] exp_b [4];
    logic [3:0] m;
    logic [1:0] s;

    initial begin
        exp_b[0] = 8'hAA; exp_b[1] = 8'hBB; exp_b[2] = 8'hCC; exp_b[3] = 8'hDD;
        a_in = '0; a_sel = '0; a_mode = 1'b0; a_iv = 1'b0; a_or = 1'b0;
        b_in = '0; b_sel = '0; b_mode = 1'b0; b_iv = 1'b0; b_or = 1'b0;
        c_in = '0; c_sel = '0; c_mode = 1'b0; c_iv = 1'b0; c_or = 1'b0;

        // ---------------- reset state ----------------
        rst = 1'b1;
        #12;
        check("rst_a_ov",   32'(a_ov),   32'd0);
        check("rst_a_out",  32'(a_out),  32'd0);
        check("rst_a_k",    32'(a_k),    32'd0);
        check("rst_a_err",  32'(a_err),  32'd0);
        check("rst_a_done", 32'(a_done), 32'd0);
        check("rst_b_ov",   32'(b_ov),   32'd0);
        check("rst_c_ov",   32'(c_ov),   32'd0);
        @(negedge clk);
        rst = 1'b0;

        // ---------------- direct sweep, one beat per cycle ----------------
        a_or = 1'b1; a_iv = 1'b1; a_mode = 1'b0;
        for (int i = 0; i < 64; i++) begin
            m = 4'(i >> 2);
            s = 2'(i);
            a_in = m; a_sel = s;
            #1 check("sweep_rdy", 32'(a_ir), 32'd1);
            @(negedge clk);
            check("sweep_dat", 32'(a_out), 32'(m[s]));
            check("sweep_k",   32'(a_k),   32'(s));
            check("sweep_ov",  32'(a_ov),  32'd1);
        end
        a_iv = 1'b0;
        @(negedge clk);
        check("drain_ov", 32'(a_ov), 32'd0);

        // ---------------- backpressure hold ----------------
        a_or = 1'b0; a_in = 4'b0100; a_sel = 2'd2; a_iv = 1'b1;
        #1 check("bp_rdy_empty", 32'(a_ir), 32'd1);
        @(negedge clk);
        a_in = 4'b0000; a_sel = 2'd0;      // offered but must not be taken while stalled
        for (int j = 0; j < 3; j++) begin
            check("bp_ov",  32'(a_ov),  32'd1);
            check("bp_dat", 32'(a_out), 32'd1);
            check("bp_k",   32'(a_k),   32'd2);
            check("bp_rdy", 32'(a_ir),  32'd0);
            @(negedge clk);
        end
        check("bp_hold_end", 32'(a_out), 32'd1);
        a_iv = 1'b0; a_or = 1'b1;
        @(negedge clk);
        check("bp_one_beat", 32'(a_ov), 32'd0);

        // ---------------- asynchronous reset mid-operation ----------------
        a_or = 1'b0; a_in = 4'b1111; a_sel = 2'd3; a_iv = 1'b1;
        @(negedge clk);
        a_iv = 1'b0;
        check("pre_rst_ov", 32'(a_ov), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_ov",  32'(a_ov),  32'd0);
        check("arst_out", 32'(a_out), 32'd0);
        check("arst_k",   32'(a_k),   32'd0);
        @(negedge clk);
        rst = 1'b0; a_or = 1'b1; a_in = 4'b0010; a_sel = 2'd1; a_iv = 1'b1;
        @(negedge clk);
        a_iv = 1'b0;
        check("post_rst_dat", 32'(a_out), 32'd1);
        check("post_rst_k",   32'(a_k),   32'd1);
        check("post_rst_ov",  32'(a_ov),  32'd1);

        // ---------------- scan, 4 x 8 bits ----------------
        b_or = 1'b1; b_in = 32'hDDCC_BBAA; b_mode = 1'b1; b_iv = 1'b1;
        @(negedge clk);
        b_in = 32'h1122_3344; b_mode = 1'b0; b_sel = 2'd1;   // ignored during scan
        check("scan0_dat",  32'(b_out),  32'hAA);
        check("scan0_k",    32'(b_k),    32'd0);
        check("scan0_done", 32'(b_done), 32'd0);
        #1 check("scan0_rdy", 32'(b_ir), 32'd0);
        for (int j = 1; j < 4; j++) begin
            @(negedge clk);
            check("scan_dat",  32'(b_out),  32'(exp_b[j]));
            check("scan_k",    32'(b_k),    32'(j));
            check("scan_ov",   32'(b_ov),   32'd1);
            check("scan_done", 32'(b_done), (j == 3) ? 32'd1 : 32'd0);
            check("scan_rdy",  32'(b_ir),   (j == 3) ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        check("after_scan_dat",  32'(b_out),  32'h33);
        check("after_scan_k",    32'(b_k),    32'd1);
        check("after_scan_done", 32'(b_done), 32'd0);

        // ---------------- scan stall, then reset mid-scan ----------------
        b_in = 32'hDDCC_BBAA; b_mode = 1'b1; b_iv = 1'b1;
        @(negedge clk);
        b_iv = 1'b0; b_or = 1'b0;
        check("stall0_dat", 32'(b_out), 32'hAA);
        @(negedge clk);
        check("stall_dat", 32'(b_out), 32'hAA);
        check("stall_k",   32'(b_k),   32'd0);
        b_or = 1'b1;
        @(negedge clk);
        check("beat1_dat", 32'(b_out), 32'hBB);
        check("beat1_k",   32'(b_k),   32'd1);
        #2 rst = 1'b1;
        #1;
        check("scan_rst_ov",  32'(b_ov),  32'd0);
        check("scan_rst_out", 32'(b_out), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            check("no_more_beats", 32'(b_ov), 32'd0);
        end
        b_mode = 1'b0; b_sel = 2'd2; b_iv = 1'b1;
        @(negedge clk);
        b_iv = 1'b0;
        check("rescan_dir_dat",  32'(b_out),  32'hCC);
        check("rescan_dir_k",    32'(b_k),    32'd2);
        check("rescan_dir_done", 32'(b_done), 32'd0);

        // ---------------- KANAL=3: out-of-range selector and short scan ----------------
        c_or = 1'b1; c_mode = 1'b0; c_in = 3'b111; c_sel = 2'd3; c_iv = 1'b1;
        @(negedge clk);
        check("oor_dat", 32'(c_out), 32'd0);
        check("oor_err", 32'(c_err), 32'd1);
        check("oor_k",   32'(c_k),   32'd3);
        check("oor_ov",  32'(c_ov),  32'd1);
        c_sel = 2'd1;
        @(negedge clk);
        check("inr_dat", 32'(c_out), 32'd1);
        check("inr_err", 32'(c_err), 32'd0);
        check("inr_k",   32'(c_k),   32'd1);
        c_in = 3'b101; c_mode = 1'b1;
        @(negedge clk);
        c_iv = 1'b0;
        check("c_scan0_dat",  32'(c_out),  32'd1);
        check("c_scan0_done", 32'(c_done), 32'd0);
        @(negedge clk);
        check("c_scan1_dat",  32'(c_out),  32'd0);
        check("c_scan1_k",    32'(c_k),    32'd1);
        check("c_scan1_done", 32'(c_done), 32'd0);
        @(negedge clk);
        check("c_scan2_dat",  32'(c_out),  32'd1);
        check("c_scan2_k",    32'(c_k),    32'd2);
        check("c_scan2_done", 32'(c_done), 32'd1);
        @(negedge clk);
        check("c_scan_end_ov", 32'(c_ov), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
